// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
// MULT/MULTU use radix-2 shift-add and DIV/DIVU use restoring division.
// Both work on magnitudes over DATA_WIDTH RUN cycles. A single FIX cycle then
// applies the sign correction and writes HI/LO. MTHI/MTLO write in one cycle.
module mdu_iter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [2:0]    OP_MTHI  = 3'b100;
    localparam logic [2:0]    OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    // Multiply: {partial product high, multiplier}; divide: {remainder, quotient}
    logic [2*W-1:0]  acc;
    // Multiplicand for multiply, divisor for divide (magnitude)
    logic [W-1:0]    opnd;
    logic            is_div_q;
    logic            neg_q;
    logic            sa_q;
    logic            bz_q;
    logic [W-1:0]    hi_q, lo_q;
    logic            done_q;

    logic            accept;
    logic            is_signed;
    logic            a_neg, b_neg;
    logic [W-1:0]    a_mag, b_mag;

    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_nxt;
    logic [W:0]      rem_sh;
    logic            div_ge;
    logic [W-1:0]    div_diff;
    logic [2*W-1:0]  div_nxt;

    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    fix_hi, fix_lo;

    assign accept    = (state == IDLE) && start && !flush;
    assign is_signed = ~op[0];
    assign a_neg     = is_signed & a[W-1];
    assign b_neg     = is_signed & b[W-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    assign busy = (state != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // One iteration of each algorithm, computed from the current accumulator
    always_comb begin
        mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_nxt  = {mul_sum, acc[W-1:1]};

        rem_sh   = acc[2*W-1:W-1];
        div_ge   = (rem_sh >= {1'b0, opnd});
        // When the trial subtract succeeds the difference is below the divisor,
        // so the low W bits hold the complete new remainder.
        div_diff = rem_sh[W-1:0] - opnd;
        div_nxt  = {(div_ge ? div_diff : rem_sh[W-1:0]), acc[W-2:0], div_ge};
    end

    assign prod_fix = neg_q ? -acc : acc;

    // Sign correction and divide-by-zero override applied in FIX
    always_comb begin
        fix_hi = prod_fix[2*W-1:W];
        fix_lo = prod_fix[W-1:0];
        if (is_div_q) begin
            fix_lo = neg_q ? -acc[W-1:0] : acc[W-1:0];
            fix_hi = sa_q ? -acc[2*W-1:W] : acc[2*W-1:W];
            if (bz_q) begin
                fix_lo = '1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush returns to IDLE from any busy state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && !op[2]) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture on acceptance and one algorithm step per RUN cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
            bz_q     <= 1'b0;
        end else if (accept && !op[2]) begin
            cnt      <= '0;
            is_div_q <= op[1];
            neg_q    <= a_neg ^ b_neg;
            sa_q     <= a_neg;
            bz_q     <= (b == '0);
            if (op[1]) begin
                acc  <= {{W{1'b0}}, a_mag};
                opnd <= b_mag;
            end else begin
                acc  <= {{W{1'b0}}, b_mag};
                opnd <= a_mag;
            end
        end else if (state == RUN) begin
            acc <= is_div_q ? div_nxt : mul_nxt;
            cnt <= cnt + CW'(1);
        end
    end

    // Architectural HI/LO and the registered done pulse
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept && op[2]) begin
                done_q <= 1'b1;
                if (op == OP_MTHI) begin
                    hi_q <= a;
                end
                if (op == OP_MTLO) begin
                    lo_q <= a;
                end
            end else if (state == FIX && !flush) begin
                done_q <= 1'b1;
                hi_q   <= fix_hi;
                lo_q   <= fix_lo;
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter. It runs table vectors, hand-written
// corner sequences and randomized ops against an arithmetic reference model.
module tb_mdu_iter;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic        start8 = 1'b0;
    logic        flush8 = 1'b0;
    logic [2:0]  op8 = '0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8, done8;
    logic [7:0]  hi8, lo8;

    always #5 clk = ~clk;

    mdu_iter #(.DATA_WIDTH(32)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    mdu_iter #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .resetn(resetn), .start(start8), .op(op8), .a(a8), .b(b8),
        .flush(flush8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result of one op, from plain 64-bit arithmetic
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          px, py, q, r, p;
        longint unsigned ux, uy, uq, ur, up;
        px = $signed(x);
        py = $signed(y);
        ux = x;
        uy = y;
        case (o)
            3'd0: begin p = px * py; {m_hi, m_lo} = p; end
            3'd1: begin up = ux * uy; {m_hi, m_lo} = up; end
            3'd2: begin
                if (y == 0) begin m_hi = x; m_lo = '1; end
                else begin q = px / py; r = px % py; m_lo = q[31:0]; m_hi = r[31:0]; end
            end
            3'd3: begin
                if (y == 0) begin m_hi = x; m_lo = '1; end
                else begin uq = ux / uy; ur = ux % uy; m_lo = uq[31:0]; m_hi = ur[31:0]; end
            end
            3'd4: m_hi = x;
            3'd5: m_lo = x;
            default: ;
        endcase
    endtask

    // Issue one op at a negedge; returns at the negedge where done is seen
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input string tag);
        int          n;
        logic        md;
        logic [31:0] old_hi, old_lo;
        md = (o[2] == 1'b0);
        old_hi = m_hi;
        old_lo = m_lo;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom; op = 3'($urandom);
        model(o, x, y);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (n == 1) chk({tag, " busy"}, busy, md);
            if (md && n == W / 2) begin
                chk({tag, " hi stable"}, hi, old_hi);
                chk({tag, " lo stable"}, lo, old_lo);
            end
            if (done) break;
        end
        chk({tag, " latency"}, n, md ? W + 2 : 1);
        chk({tag, " hi"}, hi, m_hi);
        chk({tag, " lo"}, lo, m_lo);
        chk({tag, " busy@done"}, busy, 0);
    endtask

    task automatic do_op8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] eh, input logic [7:0] el, input string tag);
        int n;
        op8 = o; a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (done8) break;
        end
        chk({tag, " latency"}, n, 10);
        chk({tag, " hi"}, hi8, eh);
        chk({tag, " lo"}, lo8, el);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          n;
        logic        saw;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        tbl[0] = '{"MULT neg", 3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        tbl[1] = '{"MULTU", 3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA};
        tbl[2] = '{"DIV neg", 3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[3] = '{"DIVU", 3'd3, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
        tbl[4] = '{"DIV ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        tbl[5] = '{"DIVU by0", 3'd3, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF};
        tbl[6] = '{"DIV by0", 3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        tbl[7] = '{"DIV nn", 3'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003};

        // Reset state
        #12;
        chk("rst hi", hi, 0);
        chk("rst lo", lo, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("post-rst busy", busy, 0);

        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].name);
            chk({tbl[i].name, " tbl hi"}, hi, tbl[i].hi);
            chk({tbl[i].name, " tbl lo"}, lo, tbl[i].lo);
        end

        // start while busy is ignored
        op = 3'd0; a = 32'hFFFF_FFFE; b = 32'h3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        op = 3'd3; a = 32'd7; b = 32'd2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 4;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
        chk("ignore latency", n, W + 2);
        chk("ignore hi", hi, 32'hFFFF_FFFF);
        chk("ignore lo", lo, 32'hFFFF_FFFA);
        @(negedge clk);
        chk("ignore done once", done, 0);
        chk("ignore busy", busy, 0);
        m_hi = 32'hFFFF_FFFF;
        m_lo = 32'hFFFF_FFFA;

        // flush mid-RUN
        op = 3'd2; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush busy", busy, 0);
        chk("flush done", done, 0);
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) saw = 1'b1;
        end
        chk("flush quiet", saw, 0);
        chk("flush hi", hi, 32'hFFFF_FFFF);
        chk("flush lo", lo, 32'hFFFF_FFFA);

        // MTLO
        op = 3'd5; a = 32'hA5A5_A5A5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("mtlo lo", lo, 32'hA5A5_A5A5);
        chk("mtlo busy", busy, 0);
        @(negedge clk);
        chk("mtlo done", done, 1);
        chk("mtlo busy2", busy, 0);
        @(negedge clk);
        chk("mtlo done off", done, 0);
        chk("mtlo hi", hi, 32'hFFFF_FFFF);
        m_lo = 32'hA5A5_A5A5;

        // start+flush with MTHI: not accepted
        op = 3'd4; a = 32'h1234_5678; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        chk("mthi+flush hi", hi, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("mthi+flush done", done, 0);

        do_op(3'd4, 32'hDEAD_BEEF, 32'h0, "MTHI");
        do_op(3'd6, 32'h1111_1111, 32'h2222_2222, "reserved");

        // Randomized ops, back-to-back with occasional idle gaps
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = '1; end
                2, 3: rb = 32'($urandom_range(1, 15));
                4: ra = 32'($urandom_range(0, 255));
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            do_op(ro, ra, rb, "rand");
        end

        // Asynchronous reset mid-RUN
        @(negedge clk);
        op = 3'd0; a = 32'h0000_1234; b = 32'h0000_5678; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("midrst hi", hi, 0);
        chk("midrst lo", lo, 0);
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        @(negedge clk);
        resetn = 1'b1;
        m_hi = '0;
        m_lo = '0;
        do_op(3'd1, 32'h0001_0000, 32'h0003_0000, "after rst");

        // DATA_WIDTH=8 instance
        @(negedge clk);
        do_op8(3'd1, 8'hFF, 8'hFF, 8'hFE, 8'h01, "w8 MULTU");
        do_op8(3'd2, 8'hF9, 8'h02, 8'hFF, 8'hFD, "w8 DIV");
        do_op8(3'd2, 8'h80, 8'hFF, 8'h00, 8'h80, "w8 DIV ovf");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised iterative multiply/divide unit for the MIPS core, owning the architectural HI/LO registers. It executes MULT, MULTU, DIV and DIVU over DATA_WIDTH+1 cycles, and MTHI/MTLO in a single cycle. It sits beside the combinational ALU in EX. The pipeline stalls on `busy` and reads `hi`/`lo` directly for MFHI/MFLO.

## Interface
- DATA_WIDTH, 32: operand width W; HI and LO are each W bits. Must be ≥ 4 and even.
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- start  in  1  request strobe; accepted only when `busy`=0
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved (accepted, no effect, `done` still pulses)
- a  in  W  rs operand (dividend / multiplicand / MTHI-MTLO source)
- b  in  W  rt operand (divisor / multiplier)
- flush  in  1  abort the in-flight operation (exception / branch squash)
- busy  out  1  high while an iterative op is in flight
- done  out  1  one-cycle pulse when HI/LO have been updated by an accepted op
- hi  out  W  HI register
- lo  out  W  LO register

## Operation
- **States:** IDLE, RUN, FIX. Step counter `cnt` is ceil(log2(W+1)) bits.
- **Reset** (resetn=0, immediately and asynchronously): state=IDLE, busy=0, done=0, hi=0, lo=0, cnt=0.
- **Acceptance:** `start`=1 && `flush`=0 in IDLE.
  - Mul/div ops latch |a| and |b| (for signed ops), latch the signs and op, and move to RUN with cnt=0.
  - MTHI/MTLO write hi (or lo) = a at the same edge and stay in IDLE.
  - Reserved ops change nothing.
- **RUN, multiply:** radix-2 shift-add. Each cycle adds the multiplicand to a 2W-bit partial product when the current multiplier bit is 1, then shifts.
- **RUN, divide:** restoring division. Each cycle shifts the 2W-bit remainder/quotient left, trial-subtracts the divisor, and keeps the difference if it is non-negative (quotient bit=1).
- **RUN exit:** after exactly W iterations (cnt reaches W−1, then transitions), go to FIX.
- **FIX:** apply sign correction, write hi/lo, pulse done, return to IDLE.
  - Signed MULT: negate the 2W-bit product if sign(a)≠sign(b). {hi,lo} = product.
  - DIV/DIVU: lo = quotient, hi = remainder. Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
- **Divide by zero** (b=0, DIV or DIVU): lo = all ones, hi = a. No trap.
- **Signed overflow** (a = −2^(W−1), b = −1, DIV): lo = −2^(W−1), hi = 0, i.e. two's-complement wrap.
- **start while busy:** ignored. No queueing; the inputs are not sampled.
- **flush in RUN or FIX:** next edge goes to IDLE, busy=0, no done pulse, hi/lo unchanged.
- **flush and start in the same cycle:** flush wins and the op is not accepted. This includes MTHI/MTLO.
- All arithmetic is modulo 2^(2W) internally. No overflow or carry outputs.

## Timing
- **Mul/div:** start accepted at edge E0.
  - busy=1 from after E0 through the cycle ending at edge E(W+1).
  - RUN occupies edges E1..EW. FIX writes hi/lo at edge E(W+1).
  - After E(W+1): done=1 for exactly one cycle, busy=0.
  - Latency is W+1 cycles (33 for W=32).
- **Back-to-back:** the next start may be accepted at E(W+1)'s following edge, i.e. in the cycle where done=1.
- **MTHI/MTLO:** hi/lo updated at E0. done=1 in the following cycle. busy stays 0.
- **Stability:** hi/lo are stable and architecturally old during RUN. They change only at a FIX edge, an MTHI/MTLO edge, or reset.
- **done:** registered, never combinational from start.
- **Reset mid-RUN:** all state clears asynchronously. Operation resumes from IDLE after resetn rises.

## Test plan
- **MULT, W=32:** a=0xFFFFFFFE (−2), b=0x00000003 → after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA, done for 1 cycle; MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- **DIV signs:** a=−7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1); DIVU a=7, b=2 → lo=3, hi=1.
- **Corner divides:** DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0; DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234.
- **Busy / ignore / flush:** start MULT, pulse start with DIVU at cycle 5 → ignored, result is the MULT result. Then start DIV and assert flush at cycle 10 → busy drops next cycle, no done, hi/lo keep the MULT result.
- **MTHI/MTLO:** MTLO a=0xA5A5A5A5 → lo updates next edge, done one cycle, busy never high. Simultaneous start+flush with MTHI → hi unchanged, no done.
- **Parametric and reset:** DATA_WIDTH=8, MULTU 0xFF×0xFF → hi=0xFE, lo=0x01 after 9 cycles. Assert resetn=0 mid-RUN → hi=lo=0, busy=0 immediately.
